// File: rtl/two_sec_timer.sv
// two_sec_timer: answers a "wait N ticks" request from the game FSM.
// A prescaler divides clk_50M down to the tick rate. The counter then counts
// DELAY_TICKS ticks and raises o_Done, which holds until the request is released.
// o_State exposes the FSM state register for debug and checker binding.
//
// Handshake (4-phase level): the requester raises i_Req and holds it high.
// The timer runs while i_Req is high (o_Busy=1), then asserts o_Done and
// holds it for as long as i_Req stays high. The requester then drops i_Req,
// and o_Done falls after the next edge. Dropping i_Req before o_Done aborts
// the delay without a done pulse. A new delay needs i_Req low for at least
// one edge first.
module two_sec_timer #(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 2000,
  parameter int DELAY_TICKS = 4000,
  parameter int WIDTH       = 12
) (
  input  logic             clk_50M,
  input  logic             i_Reset_n,
  input  logic             i_Req,
  input  logic             i_Pause,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Count,
  output logic [1:0]       o_State
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_presc;
  logic [WIDTH-1:0] r_count;

  state_t           w_state_nxt;
  logic [PW-1:0]    w_presc_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tick;
  logic [WIDTH-1:0] w_count_inc;

  assign w_tick      = (r_presc == PW'(DIV - 1));
  assign w_count_inc = r_count + WIDTH'(1);

  // State, prescaler and tick counter registers; async reset clears all of them
  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state logic: start on request, count unpaused cycles, abort on release
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (i_Req) begin
          w_state_nxt = S_RUN;
          w_presc_nxt = '0;
          w_count_nxt = '0;
        end
      end
      S_RUN: begin
        if (!i_Req) begin
          // Abort wins over a final tick on the same edge; count is kept.
          w_state_nxt = S_IDLE;
        end else if (!i_Pause) begin
          if (w_tick) begin
            w_presc_nxt = '0;
            w_count_nxt = w_count_inc;
            if (w_count_inc == WIDTH'(DELAY_TICKS)) begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end
      end
      S_DONE: begin
        if (!i_Req) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded straight from registers, so no input reaches them combinationally
  always_comb begin
    o_Busy  = (r_state == S_RUN);
    o_Done  = (r_state == S_DONE);
    o_Count = r_count;
    o_State = r_state;
  end

endmodule

// File: doc/two_sec_timer.md
Name: two_sec_timer

Overview:
- Handshake responder that serves the game FSM's "wait two seconds" request. Used for card-reveal and dealer pacing delays.
- Derives a tick from the 50 MHz system clock with an internal prescaler; no second clock domain.
- Counts a programmable number of ticks, then raises a done flag. The flag holds until the FSM releases its request (4-phase level handshake).
- Exposes the elapsed-tick count for display and debug.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TICK_HZ, 2000, tick rate in Hz. DIV = CLK_HZ/TICK_HZ, which must be an integer ≥2. Default DIV = 25000.
- DELAY_TICKS, 4000, ticks per delay, ≥1. The default gives 2 s.
- WIDTH, 12, width of the elapsed-tick counter. Must satisfy 2^WIDTH > DELAY_TICKS.

Ports:
- clk_50M  in  1  system clock, all logic on the rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Req  in  1  level request from the FSM. High means "start/continue delay".
- i_Pause  in  1  while high in RUN, prescaler and tick count freeze.
- o_Busy  out  1  high in RUN.
- o_Done  out  1  high in DONE; 4-phase acknowledge.
- o_Count  out  WIDTH  elapsed ticks of the current or last delay.

Behaviour:
- Reset (i_Reset_n low, async): state=IDLE, prescaler=0, count=0, o_Busy=0, o_Done=0, o_Count=0.
- Reset is honoured mid-delay and in DONE: immediate return to the reset values with no done pulse.
- All outputs are registered (state-decoded from registers); no combinational path from inputs to outputs.
- States:
  - IDLE: o_Busy=0, o_Done=0. o_Count holds the last value.
    - i_Req=1 at an edge → RUN; prescaler and count cleared at that same edge.
  - RUN: o_Busy=1.
    - Each edge with i_Pause=0: prescaler increments.
    - When prescaler==DIV-1 it wraps to 0 (tick) and count increments.
    - Tick that makes count==DELAY_TICKS → DONE at that edge.
    - i_Pause=1: prescaler and count hold; state stays RUN.
    - i_Req=0 at any edge → IDLE (abort); count holds, o_Done never asserts.
    - Abort has priority over a simultaneous final tick.
  - DONE: o_Done=1, o_Busy=0, o_Count=DELAY_TICKS.
    - Stays in DONE while i_Req=1.
    - i_Req=0 → IDLE; o_Done low the cycle after.
    - No new delay starts without i_Req first returning low.
- Latency: with i_Req sampled high at edge E and no pause, o_Done is high after edge E+DIV*DELAY_TICKS. Pause cycles add 1:1.
- The count never exceeds DELAY_TICKS; no wrap-around is possible.
- i_Pause has no effect in IDLE or DONE.
- Re-request straight after abort (i_Req low one cycle, then high) restarts from zero.

Test Plan (bench params CLK_HZ=8, TICK_HZ=2 → DIV=4, DELAY_TICKS=3, WIDTH=4):
1. Reset: assert i_Reset_n=0 mid-RUN, asynchronously between edges → o_Busy/o_Done/o_Count drop to 0 immediately. Release, then i_Req=1 → normal 12-cycle delay.
2. Nominal: i_Req rises, sampled at edge 0 →
   - o_Busy=1 after edge 0;
   - o_Count=1, 2, 3 after edges 4, 8, 12;
   - o_Done=1, o_Busy=0 after edge 12.
   Hold i_Req 5 more cycles → o_Done stays 1. Drop i_Req → o_Done=0 after the next edge.
3. Pause: i_Pause=1 for 5 cycles starting after edge 2 → o_Done is delayed to after edge 17; o_Count holds at 0 during the pause.
4. Abort: i_Req=0 at edge 6 → IDLE, o_Count=1 held, o_Done never 1. Re-raise at edge 8 → o_Done after edge 20.
5. Abort vs final tick: i_Req=0 at edge 12 → IDLE, o_Done stays 0.
6. Handshake: hold i_Req=1 in DONE for 50 cycles → no restart, o_Count=3 constant. Toggle i_Req low one cycle then high → new delay, o_Count restarts at 0.
